dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Word-addressed data-memory target that answers load/store requests from the pipeline's MEM-stage initiator over a valid/ready request channel and a valid/ready response channel.
- Latency is configurable, so the CPU can be exercised against a memory that does not answer in a single cycle.
- Sits between the CPU memory port and on-chip storage, replacing the zero-latency data memory.
- Performs byte-lane writes and flags misaligned or out-of-range accesses.

Parameters:
DEPTH_WORDS, 256, number of 32-bit words of storage; legal word index range 0..DEPTH_WORDS-1
LATENCY, 2, cycles from request acceptance to rsp_valid rising; legal range 1..15

Ports:
clock  input  1  single clock; all state updates on its rising edge
reset  input  1  synchronous, active-high reset
req_valid  input  1  initiator presents a request
req_ready  output  1  responder can accept a request this cycle
req_we  input  1  1 = store, 0 = load
req_addr  input  32  byte address; word index = req_addr[31:2]
req_wdata  input  32  store data
req_be  input  4  byte enables for stores; bit i gates bits [8i+7:8i]
rsp_valid  output  1  response available
rsp_ready  input  1  initiator accepts the response
rsp_rdata  output  32  load data; 0 for stores and for error responses
rsp_err  output  1  request was misaligned or out of range

Behaviour:
- Reset is synchronous and active-high. Interface fields: clock, reset.
- Reset values: state=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, latency counter=0.
- Storage contents are not cleared by reset.
- FSM states are IDLE, BUSY and RESP.
  - req_ready = (state==IDLE). It is decoded from registered state only and never depends on req_valid.
- IDLE:
  - On a rising edge with req_valid && req_ready, capture we, addr, wdata and be.
  - If LATENCY==1, go to RESP. Otherwise load the counter with LATENCY-2 and go to BUSY.
- BUSY:
  - Decrement the counter each cycle.
  - Go to RESP on the edge where the counter equals 0.
- Entering RESP (one edge only):
  - Compute err = (addr[1:0]!=0) || (addr[31:2] >= DEPTH_WORDS).
  - Store without error: write each enabled byte lane; set rsp_rdata=0.
  - Load without error: set rsp_rdata to the full word (req_be ignored).
  - Error: no storage write; rsp_rdata=0, rsp_err=1.
  - rsp_valid is 1 from this edge onward.
- Latency: if acceptance occurs at edge T, rsp_valid is first high in the cycle after edge T+LATENCY-1. That is LATENCY cycles after the acceptance cycle.
- RESP:
  - rsp_valid, rsp_rdata and rsp_err are held constant until a rising edge with rsp_ready=1.
  - On that edge: go to IDLE, clear rsp_valid, rsp_err and rsp_rdata to 0.
  - req_ready is high in the following cycle.
  - There is no same-cycle response-to-request overlap; peak throughput is one request per LATENCY+1 cycles.
- rsp_ready while rsp_valid=0 is ignored.
- req_valid while req_ready=0 is ignored; request inputs need only be stable on the acceptance edge.
- A store is committed exactly once, at the RESP-entry edge, so read-after-write through this block is always coherent.
- Reset asserted in BUSY or RESP abandons the transaction.
  - A pending store that has not reached the RESP-entry edge is not written.
  - If reset coincides with the RESP-entry edge, reset wins and no write occurs.
- A store with req_be=0000 is legal: nothing is written, and the response has err=0 unless the address is bad.

Test Plan:
1. LATENCY=2: store 0xDEADBEEF to addr 0x10 with be=1111, then load 0x10. Each rsp_valid appears 2 cycles after acceptance; load returns 0xDEADBEEF, err=0.
2. Store 0x11223344 to 0x10 with be=0101 over 0xDEADBEEF, then load. Expect rdata 0xDE22BE44.
3. Store to 0x13 (misaligned), then load 0x10. Store response has err=1 and rdata=0; load returns unchanged 0xDE22BE44.
4. DEPTH_WORDS=256: load 0x400. Expect err=1, rdata=0; a store to 0x400 does not alias word 0, which still reads its prior value.
5. Hold rsp_ready=0 for 5 cycles with req_valid=1 throughout. rsp_valid and rdata stay stable and req_ready stays 0; the second request is accepted only in the cycle after the response handshake.
6. Accept a store 0xCAFEF00D to 0x20, then assert reset one cycle later (still BUSY). After reset req_ready=1 and rsp_valid=0, and a load of 0x20 returns its pre-test value.
7. LATENCY=1: a load's rsp_valid appears in the cycle immediately after acceptance.

Source files
------------

// File: rtl/dmem_responder.sv
// dmem_responder: word-addressed data-memory target for the MEM-stage initiator.
// Accepts one load/store per transaction over a valid/ready request channel,
// answers LATENCY cycles later over a valid/ready response channel, performs
// byte-lane writes and flags misaligned or out-of-range accesses.
//
// Ports:
//   clock      - single clock, rising edge
//   reset      - synchronous, active-high
//   req_valid  - request present          req_ready - responder idle, can accept
//   req_we     - 1 store / 0 load         req_addr  - byte address (word = [31:2])
//   req_wdata  - store data               req_be    - store byte enables
//   rsp_valid  - response present         rsp_ready - initiator takes response
//   rsp_rdata  - load data (0 for stores/errors)
//   rsp_err    - misaligned or out-of-range request
module dmem_responder #(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned LATENCY     = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int unsigned CW = 4;
    localparam logic [CW-1:0] CNT_INIT = (LATENCY > 1) ? CW'(LATENCY - 2) : '0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t         state_q, state_nxt;
    logic [CW-1:0]  cnt_q, cnt_nxt;

    logic           we_q;
    logic [31:0]    addr_q;
    logic [31:0]    wdata_q;
    logic [3:0]     be_q;

    logic [31:0]    mem [DEPTH_WORDS];

    logic           capture;
    logic           enter_resp;
    logic           mem_wr;
    logic           addr_err;
    logic           eff_we;
    logic [31:0]    eff_addr;
    logic [31:0]    eff_wdata;
    logic [3:0]     eff_be;
    logic [AW-1:0]  word_idx;
    logic           rsp_valid_nxt;
    logic [31:0]    rsp_rdata_nxt;
    logic           rsp_err_nxt;

    // With LATENCY==1 the RESP-entry edge is the acceptance edge, so the live
    // request fields are used; otherwise the captured copy is used.
    always_comb begin
        if (state_q == IDLE) begin
            eff_we    = req_we;
            eff_addr  = req_addr;
            eff_wdata = req_wdata;
            eff_be    = req_be;
        end else begin
            eff_we    = we_q;
            eff_addr  = addr_q;
            eff_wdata = wdata_q;
            eff_be    = be_q;
        end
    end

    assign word_idx = eff_addr[AW+1:2];
    assign addr_err = (eff_addr[1:0] != 2'b00) ||
                      ({2'b00, eff_addr[31:2]} >= 32'(DEPTH_WORDS));

    // Next-state, counter and response-register logic
    always_comb begin
        state_nxt     = state_q;
        cnt_nxt       = cnt_q;
        capture       = 1'b0;
        enter_resp    = 1'b0;
        mem_wr        = 1'b0;
        rsp_valid_nxt = rsp_valid;
        rsp_rdata_nxt = rsp_rdata;
        rsp_err_nxt   = rsp_err;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    capture = 1'b1;
                    if (LATENCY == 1) begin
                        enter_resp = 1'b1;
                    end else begin
                        cnt_nxt   = CNT_INIT;
                        state_nxt = BUSY;
                    end
                end
            end
            BUSY: begin
                if (cnt_q == '0) begin
                    enter_resp = 1'b1;
                end else begin
                    cnt_nxt = cnt_q - CW'(1);
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_nxt     = IDLE;
                    rsp_valid_nxt = 1'b0;
                    rsp_rdata_nxt = '0;
                    rsp_err_nxt   = 1'b0;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        // Single commit point: error check, store write and load read
        if (enter_resp) begin
            state_nxt     = RESP;
            rsp_valid_nxt = 1'b1;
            rsp_err_nxt   = addr_err;
            mem_wr        = eff_we && !addr_err;
            rsp_rdata_nxt = (!eff_we && !addr_err) ? mem[word_idx] : '0;
        end
    end

    // Control and response registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            state_q   <= state_nxt;
            cnt_q     <= cnt_nxt;
            req_ready <= (state_nxt == IDLE);
            rsp_valid <= rsp_valid_nxt;
            rsp_rdata <= rsp_rdata_nxt;
            rsp_err   <= rsp_err_nxt;
        end
    end

    // Request capture; datapath only, no reset needed
    always_ff @(posedge clock) begin
        if (capture) begin
            we_q    <= req_we;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            be_q    <= req_be;
        end
    end

    // Storage with byte-lane writes; reset blocks a coinciding commit
    always_ff @(posedge clock) begin
        if (!reset && mem_wr) begin
            for (int i = 0; i < 4; i++) begin
                if (eff_be[i]) begin
                    mem[word_idx][8*i +: 8] <= eff_wdata[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed bench for dmem_responder (LATENCY=2 and LATENCY=1).
module tb_dmem_responder;

    logic        clock;
    logic        reset;
    logic        req_valid, req_ready, req_we;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_be;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_rdata;

    logic        f_req_valid, f_req_ready, f_req_we;
    logic [31:0] f_req_addr, f_req_wdata;
    logic [3:0]  f_req_be;
    logic        f_rsp_valid, f_rsp_ready, f_rsp_err;
    logic [31:0] f_rsp_rdata;

    int checks = 0;
    int errors = 0;
    int lat;

    dmem_responder #(.DEPTH_WORDS(256), .LATENCY(2)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    dmem_responder #(.DEPTH_WORDS(256), .LATENCY(1)) dut1 (
        .clock(clock), .reset(reset),
        .req_valid(f_req_valid), .req_ready(f_req_ready), .req_we(f_req_we),
        .req_addr(f_req_addr), .req_wdata(f_req_wdata), .req_be(f_req_be),
        .rsp_valid(f_rsp_valid), .rsp_ready(f_rsp_ready),
        .rsp_rdata(f_rsp_rdata), .rsp_err(f_rsp_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Present a request and return just after its acceptance edge
    task automatic send(input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] be);
        int n;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        req_be    = be;
        n = 0;
        while (!req_ready && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) check("req_ready_timeout", 32'(req_ready), 32'd1);
        tick();
        req_valid = 1'b0;
    endtask

    // Cycles from the acceptance cycle until rsp_valid is seen
    task automatic wait_rsp(output int l);
        l = 1;
        while (!rsp_valid && l < 50) begin
            tick();
            l++;
        end
    endtask

    task automatic finish_rsp(input string tag);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check({tag, "_valid_clr"}, 32'(rsp_valid), 32'd0);
        check({tag, "_ready_back"}, 32'(req_ready), 32'd1);
    endtask

    task automatic xact(input string tag, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] be,
                        input logic [31:0] exp_rdata, input logic exp_err);
        int l;
        send(we, addr, wdata, be);
        wait_rsp(l);
        check({tag, "_lat"}, 32'(l), 32'd2);
        check({tag, "_rdata"}, rsp_rdata, exp_rdata);
        check({tag, "_err"}, 32'(rsp_err), 32'(exp_err));
        finish_rsp(tag);
    endtask

    initial begin
        reset       = 1'b1;
        req_valid   = 1'b0;
        req_we      = 1'b0;
        req_addr    = '0;
        req_wdata   = '0;
        req_be      = '0;
        rsp_ready   = 1'b0;
        f_req_valid = 1'b0;
        f_req_we    = 1'b0;
        f_req_addr  = '0;
        f_req_wdata = '0;
        f_req_be    = '0;
        f_rsp_ready = 1'b0;
        tick(); tick(); tick();

        // Reset state
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_rdata", rsp_rdata, 32'd0);
        check("rst_rsp_err", 32'(rsp_err), 32'd0);
        reset = 1'b0;
        tick();

        // Known contents used later
        xact("init20", 1'b1, 32'h20, 32'h1234_5678, 4'b1111, 32'h0, 1'b0);
        xact("init00", 1'b1, 32'h00, 32'h0BAD_F00D, 4'b1111, 32'h0, 1'b0);

        // Full store then load
        xact("st10", 1'b1, 32'h10, 32'hDEAD_BEEF, 4'b1111, 32'h0, 1'b0);
        xact("ld10a", 1'b0, 32'h10, 32'h0, 4'b0000, 32'hDEAD_BEEF, 1'b0);

        // Partial byte-lane store
        xact("st10be", 1'b1, 32'h10, 32'h1122_3344, 4'b0101, 32'h0, 1'b0);
        xact("ld10b", 1'b0, 32'h10, 32'h0, 4'b1111, 32'hDE22_BE44, 1'b0);

        // Zero byte enables write nothing
        xact("st10be0", 1'b1, 32'h10, 32'hFFFF_FFFF, 4'b0000, 32'h0, 1'b0);
        xact("ld10c", 1'b0, 32'h10, 32'h0, 4'b0000, 32'hDE22_BE44, 1'b0);

        // Misaligned store is rejected
        xact("st13", 1'b1, 32'h13, 32'hFFFF_FFFF, 4'b1111, 32'h0, 1'b1);
        xact("ld10d", 1'b0, 32'h10, 32'h0, 4'b0000, 32'hDE22_BE44, 1'b0);
        xact("ld12", 1'b0, 32'h12, 32'h0, 4'b0000, 32'h0, 1'b1);

        // Out of range, no aliasing onto word 0; last legal word works
        xact("ld400", 1'b0, 32'h400, 32'h0, 4'b0000, 32'h0, 1'b1);
        xact("st400", 1'b1, 32'h400, 32'h5555_5555, 4'b1111, 32'h0, 1'b1);
        xact("ld00", 1'b0, 32'h00, 32'h0, 4'b0000, 32'h0BAD_F00D, 1'b0);
        xact("st3fc", 1'b1, 32'h3FC, 32'hA5A5_5A5A, 4'b1111, 32'h0, 1'b0);
        xact("ld3fc", 1'b0, 32'h3FC, 32'h0, 4'b0000, 32'hA5A5_5A5A, 1'b0);

        // Backpressure: response held, next request waits
        send(1'b0, 32'h10, 32'h0, 4'b0000);
        wait_rsp(lat);
        check("bp_lat", 32'(lat), 32'd2);
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 32'h20;
        for (int i = 0; i < 5; i++) begin
            check("bp_hold_valid", 32'(rsp_valid), 32'd1);
            check("bp_hold_rdata", rsp_rdata, 32'hDE22_BE44);
            check("bp_hold_ready", 32'(req_ready), 32'd0);
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("bp_valid_clr", 32'(rsp_valid), 32'd0);
        check("bp_rdata_clr", rsp_rdata, 32'd0);
        check("bp_ready_back", 32'(req_ready), 32'd1);
        tick();
        req_valid = 1'b0;
        check("bp_second_accepted", 32'(req_ready), 32'd0);
        wait_rsp(lat);
        check("bp2_lat", 32'(lat), 32'd2);
        check("bp2_rdata", rsp_rdata, 32'h1234_5678);
        finish_rsp("bp2");

        // Reset while BUSY, coinciding with the would-be commit edge
        send(1'b1, 32'h20, 32'hCAFE_F00D, 4'b1111);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort_req_ready", 32'(req_ready), 32'd1);
        check("abort_rsp_valid", 32'(rsp_valid), 32'd0);
        check("abort_rsp_err", 32'(rsp_err), 32'd0);
        tick();
        check("abort_still_idle", 32'(rsp_valid), 32'd0);
        xact("ld20", 1'b0, 32'h20, 32'h0, 4'b0000, 32'h1234_5678, 1'b0);

        // LATENCY=1 instance: response in the cycle right after acceptance
        check("l1_ready", 32'(f_req_ready), 32'd1);
        f_req_valid = 1'b1;
        f_req_we    = 1'b1;
        f_req_addr  = 32'h8;
        f_req_wdata = 32'h600D_CAFE;
        f_req_be    = 4'b1111;
        tick();
        f_req_valid = 1'b0;
        check("l1_st_valid", 32'(f_rsp_valid), 32'd1);
        check("l1_st_err", 32'(f_rsp_err), 32'd0);
        check("l1_st_rdata", f_rsp_rdata, 32'd0);
        f_rsp_ready = 1'b1;
        tick();
        f_rsp_ready = 1'b0;
        check("l1_st_clr", 32'(f_rsp_valid), 32'd0);
        f_req_valid = 1'b1;
        f_req_we    = 1'b0;
        tick();
        f_req_valid = 1'b0;
        check("l1_ld_valid", 32'(f_rsp_valid), 32'd1);
        check("l1_ld_rdata", f_rsp_rdata, 32'h600D_CAFE);
        f_rsp_ready = 1'b1;
        tick();
        f_rsp_ready = 1'b0;
        check("l1_ld_clr", 32'(f_rsp_valid), 32'd0);
        check("l1_ready_back", 32'(f_req_ready), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
